// File: rtl/transmitter.sv
// 8N1 serial transmitter: bytes queue in a small FIFO and are framed
// (start, 8 data LSB-first, stop) onto a registered, idle-high line.
module transmitter #(
    parameter int unsigned T     = 2604,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     OUT
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(T);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         sr_q, sr_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;

    logic               push_c;
    logic               pop_c;
    logic               bit_done_c;

    assign push_c     = wr_en && !full_q;
    assign bit_done_c = (cnt_q == BIT_W'(T - 1));

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: decisions use the registered empty flag only
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) state_d = S_START;
            end
            S_START: begin
                if (bit_done_c) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_done_c && (idx_q == 3'd7)) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_done_c) state_d = empty_q ? S_IDLE : S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: line level, shift register, bit timing and FIFO pop
    always_comb begin
        pop_c = 1'b0;
        out_d = out_q;
        sr_d  = sr_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                if (!empty_q) begin
                    pop_c = 1'b1;
                    sr_d  = mem[rd_ptr_q];
                    out_d = 1'b0;
                    cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_done_c) begin
                    out_d = sr_q[0];
                    idx_d = 3'd0;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + BIT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        out_d = 1'b1;
                    end else begin
                        sr_d  = {1'b0, sr_q[7:1]};
                        out_d = sr_q[1];
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + BIT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    cnt_d = '0;
                    if (!empty_q) begin
                        pop_c = 1'b1;
                        sr_d  = mem[rd_ptr_q];
                        out_d = 1'b0;
                    end else begin
                        out_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + BIT_W'(1);
                end
            end
            default: begin
                out_d = 1'b1;
            end
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d   = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d    = count_q + OCC_W'(push_c) - OCC_W'(pop_c);
        full_d     = (count_d == OCC_W'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge CLK) begin
        if (push_c) mem[wr_ptr_q] <= data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sr_q       <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign OUT      = out_q;
    assign busy     = busy_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: a frame-timeline reference model predicts the line,
// FIFO flags and busy every cycle; a second instance checks the full-size divisor.
module tb_transmitter;

    localparam int T     = 4;
    localparam int DEPTH = 4;
    localparam int TB    = 2604;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] data, data_b;
    logic       wr_en, wr_en_b;
    logic       full, empty, busy, overflow, OUT;
    logic [2:0] count;
    logic       full_b, empty_b, busy_b, overflow_b, OUT_b;
    logic [4:0] count_b;

    transmitter #(.T(T), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .data(data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count),
        .busy(busy), .overflow(overflow), .OUT(OUT)
    );

    transmitter #(.T(TB), .DEPTH(16)) dut_big (
        .CLK(CLK), .RST(RST), .data(data_b), .wr_en(wr_en_b),
        .full(full_b), .empty(empty_b), .count(count_b),
        .busy(busy_b), .overflow(overflow_b), .OUT(OUT_b)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes, start edge of the current frame, its byte
    logic [7:0] mq[$];
    longint     fs;
    longint     cyc;
    longint     last_edge;
    logic [7:0] cur;
    logic       m_ovf;

    task automatic model_reset();
        mq.delete();
        fs    = -100000;
        cyc   = 0;
        m_ovf = 1'b0;
        cur   = 8'h00;
    endtask

    function automatic logic exp_line(longint n);
        longint k;
        if (n < fs || n >= fs + 10 * T) return 1'b1;
        k = (n - fs) / T;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur[int'(k - 1)];
    endfunction

    function automatic logic exp_busy(longint n);
        return (n >= fs) && (n < fs + 10 * T);
    endfunction

    // One clock edge: a new frame may start whenever the previous one is over
    task automatic cycle(input logic we, input logic [7:0] d);
        logic pre_full;
        logic do_pop;
        wr_en    = we;
        data     = d;
        wr_en_b  = 1'b0;
        pre_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() != 0) && (cyc >= fs + 10 * T);
        if (we && pre_full) m_ovf = 1'b1;
        if (do_pop) begin
            cur = mq.pop_front();
            fs  = cyc;
        end
        if (we && !pre_full) mq.push_back(d);
        @(posedge CLK);
        #1;
        wr_en     = 1'b0;
        last_edge = cyc;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST     = 1'b1;
        wr_en   = 1'b0;
        wr_en_b = 1'b0;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; wr_en = 1'b0; wr_en_b = 1'b0; data = 8'h00; data_b = 8'h00;
        model_reset();
        #1;
        n_checks++; if (OUT !== 1'b1) begin n_fail++; $display("FAIL reset_out: got %b want 1", OUT); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single();
        cycle(1'b1, 8'h55);
        n_checks++; if (OUT !== 1'b1) begin n_fail++; $display("FAIL single_pre: got %b want 1", OUT); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
        cycle(1'b0, 8'h00);
        n_checks++; if (OUT !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", OUT); end
        for (int i = 0; i < 10 * T + 6; i++) begin
            cycle(1'b0, 8'h00);
            n_checks++;
            if (OUT !== exp_line(last_edge)) begin
                n_fail++; $display("FAIL single_line @%0d: got %b want %b", last_edge, OUT, exp_line(last_edge));
            end
            n_checks++;
            if (busy !== exp_busy(last_edge)) begin
                n_fail++; $display("FAIL single_busy @%0d: got %b want %b", last_edge, busy, exp_busy(last_edge));
            end
            n_checks++;
            if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty @%0d: got %b want 1", last_edge, empty); end
        end
    endtask

    task automatic test_two();
        int busy_cycles = 0;
        cycle(1'b1, 8'hA3);
        cycle(1'b1, 8'h0F);
        if (busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 20 * T + 8; i++) begin
            cycle(1'b0, 8'h00);
            if (busy === 1'b1) busy_cycles++;
            n_checks++;
            if (OUT !== exp_line(last_edge)) begin
                n_fail++; $display("FAIL two_line @%0d: got %b want %b", last_edge, OUT, exp_line(last_edge));
            end
            n_checks++;
            if (count !== 3'(mq.size())) begin
                n_fail++; $display("FAIL two_count @%0d: got %0d want %0d", last_edge, count, mq.size());
            end
        end
        n_checks++;
        if (busy_cycles != 20 * T) begin
            n_fail++; $display("FAIL two_busy_len: got %0d want %0d", busy_cycles, 20 * T);
        end
    endtask

    task automatic test_overflow();
        int falls = 0;
        logic prev;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom));
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
        prev = OUT;
        for (int i = 0; i < 50 * T + 8; i++) begin
            cycle(1'b0, 8'h00);
            if (prev === 1'b1 && OUT === 1'b0 && exp_line(last_edge) === 1'b0 && last_edge == fs) falls++;
            prev = OUT;
            n_checks++;
            if (OUT !== exp_line(last_edge)) begin
                n_fail++; $display("FAIL ovf_line @%0d: got %b want %b", last_edge, OUT, exp_line(last_edge));
            end
            n_checks++;
            if (full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL ovf_full_track @%0d: got %b want %b", last_edge, full, mq.size() == DEPTH);
            end
        end
        n_checks++;
        if (falls != 4) begin n_fail++; $display("FAIL ovf_frames_after_first: got %0d want 4", falls); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
        while (cyc <= fs + 4 * T + 1) cycle(1'b0, 8'h00);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_queued: got %0d want 2", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_ovf_before: got %b want 1", overflow); end
        #3;
        RST = 1'b1;
        #1;
        n_checks++; if (OUT !== 1'b1) begin n_fail++; $display("FAIL mid_out: got %b want 1", OUT); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 15 * T; i++) begin
            cycle(1'b0, 8'h00);
            n_checks++;
            if (OUT !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_quiet @%0d: got out=%b busy=%b want out=1 busy=0", last_edge, OUT, busy);
            end
        end
    endtask

    task automatic test_stop_write();
        cycle(1'b1, 8'($urandom));
        cycle(1'b0, 8'h00);
        while (cyc < fs + 10 * T - 1) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h81);
        cycle(1'b0, 8'h00);
        n_checks++; if (OUT !== 1'b0) begin n_fail++; $display("FAIL stopwr_nogap: got %b want 0", OUT); end
        for (int i = 0; i < 10 * T + 4; i++) begin
            cycle(1'b0, 8'h00);
            n_checks++;
            if (OUT !== exp_line(last_edge)) begin
                n_fail++; $display("FAIL stopwr_line @%0d: got %b want %b", last_edge, OUT, exp_line(last_edge));
            end
        end
    endtask

    task automatic test_random();
        logic we;
        int   lim;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            lim = (i < 300) ? 15 : ((i < 550) ? 2 : 40);
            we  = ($urandom_range(0, lim) == 0);
            cycle(we, 8'($urandom));
            n_checks++;
            if (OUT !== exp_line(last_edge)) begin
                n_fail++; $display("FAIL rnd_line @%0d: got %b want %b", last_edge, OUT, exp_line(last_edge));
            end
            n_checks++;
            if (busy !== exp_busy(last_edge)) begin
                n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", last_edge, busy, exp_busy(last_edge));
            end
            n_checks++;
            if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                n_fail++; $display("FAIL rnd_fifo @%0d: got count=%0d empty=%b full=%b want count=%0d", last_edge, count, empty, full, mq.size());
            end
            n_checks++;
            if (overflow !== m_ovf) begin
                n_fail++; $display("FAIL rnd_overflow @%0d: got %b want %b", last_edge, overflow, m_ovf);
            end
        end
    endtask

    task automatic test_big();
        int low = 0;
        int hi  = 0;
        @(negedge CLK);
        wr_en_b = 1'b1;
        data_b  = 8'h00;
        @(posedge CLK);
        #1;
        wr_en_b = 1'b0;
        n_checks++; if (OUT_b !== 1'b1) begin n_fail++; $display("FAIL big_pre: got %b want 1", OUT_b); end
        @(posedge CLK);
        #1;
        n_checks++; if (OUT_b !== 1'b0) begin n_fail++; $display("FAIL big_start: got %b want 0", OUT_b); end
        low = 1;
        while (OUT_b === 1'b0 && low < 30000) begin
            @(posedge CLK);
            #1;
            if (OUT_b === 1'b0) low++;
        end
        n_checks++; if (low != 9 * TB) begin n_fail++; $display("FAIL big_low_len: got %0d want %0d", low, 9 * TB); end
        while (busy_b === 1'b1 && hi < 30000) begin
            @(posedge CLK);
            #1;
            hi++;
        end
        n_checks++; if (hi != TB) begin n_fail++; $display("FAIL big_stop_len: got %0d want %0d", hi, TB); end
        n_checks++; if (OUT_b !== 1'b1) begin n_fail++; $display("FAIL big_idle: got %b want 1", OUT_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_overflow();
        test_reset_mid();
        test_stop_write();
        test_random();
        test_big();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
